// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder computing {cout,sum} = a + b + cin,
// one bit per clock, LSB first.
//
// Parameters:
//   WIDTH  operand width in bits (2..32), default 8
//
// Ports:
//   clk    clock; all state updates on its rising edge
//   rst    synchronous active-high reset
//   start  request an addition; accepted in IDLE or DONE, ignored in SHIFT
//   a, b   operands, captured when start is accepted
//   cin    carry-in, captured when start is accepted
//   busy   high while the serial addition is running
//   done   one-cycle pulse: sum/cout (and ovf) hold a new result
//   sum    result of the last completed addition (held between operations)
//   cout   carry-out of the last completed addition
//   ovf    signed overflow of the last result; present only when the macro
//          SERIAL_ADDER_OVF_EN is defined
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q,   opa_d;
  logic [WIDTH-1:0] opb_q,   opb_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,   ovf_d;
`endif

  logic fa_s, fa_c, last_bit;

  always_comb begin
    fa_s     = opa_q[0] ^ opb_q[0] ^ carry_q;
    fa_c     = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        // DONE accepts start exactly like IDLE so operations can run back to back.
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // Publish on the final bit so sum never shows a partial result.
          state_d = DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
// Stimulus pushes hand-computed results with their expected done cycle;
// a monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic [31:0]  cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done act=1 req=0 cycle=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("sum", {24'd0, sum}, {24'd0, mon_e.s});
        check("cout", {31'd0, cout}, {31'd0, mon_e.c});
        check("done_cycle", cyc, mon_e.cyc);
        check("busy_in_done", {31'd0, busy}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.v});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
  endtask

  // One isolated operation, then a hold check with changing, unaccepted inputs.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                    input logic [W-1:0] es, input logic ec, input logic ev);
    start = 1'b1; a = ia; b = ib; cin = ic;
    tick();
    sb.push_back('{s: es, c: ec, v: ev, cyc: cyc + W});
    check("busy_after_start", {31'd0, busy}, 32'd1);
    start = 1'b0;
    scramble();
    repeat (W + 2) tick();
    check("sum_hold", {24'd0, sum}, {24'd0, es});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    //  a      b      cin   sum    cout  ovf
    op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
    op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);

    // start during SHIFT cycle 3 must be ignored.
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick();
    sb.push_back('{s: 8'h46, c: 1'b0, v: 1'b0, cyc: cyc + W});
    start = 1'b0; scramble();
    repeat (2) tick();
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
    tick();
    start = 1'b0; scramble();
    repeat (W + 2) tick();
    check("ignored_start_sum", {24'd0, sum}, 32'h46);

    // start held high through DONE: back-to-back, done pulses 9 cycles apart.
    start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b1;
    tick();
    sb.push_back('{s: 8'h4C, c: 1'b0, v: 1'b0, cyc: cyc + W});
    a = 8'h01; b = 8'h01; cin = 1'b0;
    repeat (W) tick();
    check("in_done_before_restart", {31'd0, done}, 32'd1);
    sb.push_back('{s: 8'h02, c: 1'b0, v: 1'b0, cyc: cyc + 1 + W});
    tick();
    start = 1'b0; scramble();
    repeat (W + 2) tick();

    // Reset at SHIFT cycle 4 aborts with no done pulse.
    start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b0;
    tick();
    start = 1'b0; scramble();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (12) tick();

    op(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
